// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
// Holds the register file geometry, the write-arbiter state encoding and
// the packed record that describes one write-port transaction.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;

    // Arbiter state encoding, kept as plain constants so older tools and
    // netlist-level debug scripts see a fixed 1-bit code.
    localparam logic [0:0] ARB_S   = 1'b0;
    localparam logic [0:0] CLEAR_S = 1'b1;

    // Clear sequence walks r1..r31; r0 is hard-wired and never written.
    localparam logic [REG_ADDR_W-1:0] FIRST_CLR_REG = REG_ADDR_W'(ZERO_REG + 1);
    localparam logic [REG_ADDR_W-1:0] LAST_CLR_REG  = REG_ADDR_W'(NUM_REGS - 1);

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wrPort_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle between NUM_REQ requesters and the write arbiter.
//   req_valid  : per-requester write request
//   req_ready  : per-requester grant (transfer when valid & ready at an edge)
//   req_reg    : destination register, requester i in bits [5i+4:5i]
//   req_data   : write data, requester i in bits [32i+31:32i]
// master = requester side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import regfile_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [REG_ADDR_W*NUM_REQ-1:0] req_reg;
    logic [DATA_W*NUM_REQ-1:0]     req_data;

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector starting one position after ptr (wrapping)
// and grants the first asserted request.
//   req   : request vector
//   ptr   : index of the most recent winner
//   grant : one-hot grant (all zero when nothing requests)
//   idx   : encoded index of the granted requester
//   any   : at least one request is asserted
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file's single write port.
// Round-robin shares the port between NUM_REQ writeback requesters and runs
// a one-register-per-cycle clear of r1..r31 on demand.
//   clock, ctrl_reset  : clock and synchronous active-high reset
//   clear_start        : pulse that launches the clear sequence
//   clear_busy         : high while the clear sequence runs
//   reqIf              : requester valid/ready/reg/data bundle (slave side)
//   ctrl_writeEnable   : registered write enable to the register file
//   ctrl_writeReg      : registered write address
//   data_writeReg      : registered write data
//   grant_id           : requester that produced the current port contents
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  clear_start,
    output logic                  clear_busy,
    regfile_write_arbiter_if.slave reqIf,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0]     data_writeReg,
    output logic [ID_W-1:0]       grant_id
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [0:0]            state;
    logic [PTR_W-1:0]      rrPtr;
    logic [REG_ADDR_W-1:0] clearCnt;
    wrPort_t               wrPort;
    logic [ID_W-1:0]       grantIdQ;

    logic [NUM_REQ-1:0]    arbGrant;
    logic [PTR_W-1:0]      arbIdx;
    logic                  arbAny;
    logic                  arbEnable;
    logic                  accept;

    logic [REG_ADDR_W-1:0] regArr  [NUM_REQ];
    logic [DATA_W-1:0]     dataArr [NUM_REQ];
    logic [REG_ADDR_W-1:0] selReg;
    logic [DATA_W-1:0]     selData;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (PTR_W)
    ) uRrArbiter (
        .req   (reqIf.req_valid),
        .ptr   (rrPtr),
        .grant (arbGrant),
        .idx   (arbIdx),
        .any   (arbAny)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            regArr[i]  = reqIf.req_reg[i*REG_ADDR_W +: REG_ADDR_W];
            dataArr[i] = reqIf.req_data[i*DATA_W +: DATA_W];
        end
    end

    assign selReg  = regArr[arbIdx];
    assign selData = dataArr[arbIdx];

    // A clear request or reset in the same cycle suppresses every grant, so a
    // waiting requester simply keeps valid high and retries later.
    assign arbEnable       = (state == ARB_S) && !clear_start && !ctrl_reset;
    assign reqIf.req_ready = arbEnable ? arbGrant : '0;
    assign accept          = arbEnable && arbAny;

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state    <= ARB_S;
            rrPtr    <= PTR_W'(NUM_REQ - 1);
            clearCnt <= FIRST_CLR_REG;
            wrPort   <= '0;
            grantIdQ <= '0;
        end else if (state == CLEAR_S) begin
            wrPort   <= '{we: 1'b1, addr: clearCnt, data: '0};
            grantIdQ <= '0;
            if (clearCnt == LAST_CLR_REG) begin
                state    <= ARB_S;
                clearCnt <= FIRST_CLR_REG;
            end else begin
                clearCnt <= clearCnt + 1'b1;
            end
        end else if (clear_start) begin
            state     <= CLEAR_S;
            wrPort.we <= 1'b0;
        end else if (accept) begin
            // r0 writes complete the handshake but never enable the port.
            wrPort.we   <= (selReg != REG_ADDR_W'(ZERO_REG));
            wrPort.addr <= selReg;
            wrPort.data <= selData;
            grantIdQ    <= ID_W'(arbIdx);
            rrPtr       <= arbIdx;
        end else begin
            wrPort.we <= 1'b0;
        end
    end

    assign clear_busy       = (state == CLEAR_S);
    assign ctrl_writeEnable = wrPort.we;
    assign ctrl_writeReg    = wrPort.addr;
    assign data_writeReg    = wrPort.data;
    assign grant_id         = grantIdQ;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (NUM_REQ=2, ID_W=2).
// Attaches a register file behind the write port and compares the DUT with
// a transaction-level reference model of arbitration and clearing.
module tb_regfile_write_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic            clock = 1'b0;
    logic            ctrl_reset;
    logic            clear_start;
    logic            clear_busy;
    logic            ctrl_writeEnable;
    logic [4:0]      ctrl_writeReg;
    logic [31:0]     data_writeReg;
    logic [IDW-1:0]  grant_id;

    regfile_write_arbiter_if #(.NUM_REQ(NREQ)) busIf ();

    regfile_write_arbiter #(
        .NUM_REQ (NREQ),
        .ID_W    (IDW)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .clear_start      (clear_start),
        .clear_busy       (clear_busy),
        .reqIf            (busIf),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .grant_id         (grant_id)
    );

    always #5 clock = ~clock;

    // Register file attached to the write port; r0 is hard-wired zero.
    logic [31:0] rf [32];
    always @(posedge clock) begin
        if (ctrl_writeEnable && ctrl_writeReg != 5'd0)
            rf[ctrl_writeReg] <= data_writeReg;
    end

    function automatic logic [31:0] rdReg(input int a);
        return (a == 0) ? 32'd0 : rf[a];
    endfunction

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: clear sequence as a queue of pending addresses,
    // arbitration as "first valid requester after the last winner".
    int          mPtr = NREQ - 1;
    int          clrQ[$];
    bit          mWe = 1'b0;
    int          mReg = 0;
    logic [31:0] mData = 32'd0;
    int          mGid = 0;
    logic [31:0] shadow [32];
    bit [1:0]    lastReady;
    bit          lastBusy;

    task automatic doCycle(input bit rst, input bit clr, input bit [1:0] valid,
                           input bit [4:0] ra, input bit [4:0] rb,
                           input bit [31:0] da, input bit [31:0] db);
        bit [1:0] expReady;
        int g;
        @(negedge clock);
        ctrl_reset      = rst;
        clear_start     = clr;
        busIf.req_valid = valid;
        busIf.req_reg   = {rb, ra};
        busIf.req_data  = {db, da};
        #1;
        g = -1;
        if (!rst && clrQ.size() == 0 && !clr) begin
            for (int off = 1; off <= NREQ; off++) begin
                int c;
                c = (mPtr + off) % NREQ;
                if (g < 0 && ((valid >> c) & 2'b01) != 2'b00) g = c;
            end
        end
        expReady  = (g >= 0) ? (2'b01 << g) : 2'b00;
        lastReady = busIf.req_ready;
        lastBusy  = clear_busy;
        check("ready", busIf.req_ready, expReady);
        check("clear_busy", clear_busy, clrQ.size() > 0);
        @(posedge clock);
        if (mWe && mReg != 0) shadow[mReg] = mData;
        if (rst) begin
            mPtr = NREQ - 1;
            clrQ.delete();
            mWe = 1'b0; mReg = 0; mData = 32'd0; mGid = 0;
        end else if (clrQ.size() > 0) begin
            mWe = 1'b1; mReg = clrQ.pop_front(); mData = 32'd0; mGid = 0;
        end else if (clr) begin
            for (int r = 1; r < 32; r++) clrQ.push_back(r);
            mWe = 1'b0;
        end else if (g >= 0) begin
            mReg  = (g == 1) ? int'(rb) : int'(ra);
            mData = (g == 1) ? db : da;
            mWe   = (mReg != 0);
            mGid  = g;
            mPtr  = g;
        end else begin
            mWe = 1'b0;
        end
        #1;
        check("we", ctrl_writeEnable, mWe);
        check("wreg", ctrl_writeReg, mReg[4:0]);
        check("wdata", data_writeReg, mData);
        check("gid", grant_id, mGid[IDW-1:0]);
    endtask

    typedef struct {
        bit        rst;
        bit        clr;
        bit [1:0]  valid;
        bit [4:0]  ra;
        bit [4:0]  rb;
        bit [31:0] da;
        bit [31:0] db;
        bit [1:0]  expReady;
        bit        expWe;
        bit [4:0]  expReg;
        bit [31:0] expData;
        bit [1:0]  expGid;
        bit        expBusy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int busyCnt;
        int bad;
        bit [1:0]  cv;
        bit [4:0]  cr [2];
        bit [31:0] cd [2];

        tbl[0]  = '{1, 0, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 2'b00, 0, 5'd0, 32'h0, 2'd0, 0};
        tbl[1]  = '{1, 0, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 2'b00, 0, 5'd0, 32'h0, 2'd0, 0};
        tbl[2]  = '{1, 0, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 2'b00, 0, 5'd0, 32'h0, 2'd0, 0};
        tbl[3]  = '{0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 0, 5'd0, 32'h0, 2'd0, 0};
        tbl[4]  = '{0, 0, 2'b10, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 2'b10, 1, 5'd5, 32'hDEADBEEF, 2'd1, 0};
        tbl[5]  = '{0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 0, 5'd5, 32'hDEADBEEF, 2'd1, 0};
        tbl[6]  = '{1, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 0, 5'd0, 32'h0, 2'd0, 0};
        tbl[7]  = '{0, 0, 2'b11, 5'd3, 5'd4, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b01, 1, 5'd3, 32'hA0A0A0A0, 2'd0, 0};
        tbl[8]  = '{0, 0, 2'b11, 5'd3, 5'd4, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b10, 1, 5'd4, 32'hB1B1B1B1, 2'd1, 0};
        tbl[9]  = '{0, 0, 2'b11, 5'd3, 5'd4, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b01, 1, 5'd3, 32'hA0A0A0A0, 2'd0, 0};
        tbl[10] = '{0, 0, 2'b11, 5'd3, 5'd4, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b10, 1, 5'd4, 32'hB1B1B1B1, 2'd1, 0};
        tbl[11] = '{0, 0, 2'b01, 5'd0, 5'd0, 32'h12345678, 32'h0, 2'b01, 0, 5'd0, 32'h12345678, 2'd0, 0};
        tbl[12] = '{0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 0, 5'd0, 32'h12345678, 2'd0, 0};

        // Power-on reset so the DUT state is defined before checking starts.
        ctrl_reset      = 1'b1;
        clear_start     = 1'b0;
        busIf.req_valid = '0;
        busIf.req_reg   = '0;
        busIf.req_data  = '0;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 13; i++) begin
            doCycle(tbl[i].rst, tbl[i].clr, tbl[i].valid, tbl[i].ra, tbl[i].rb, tbl[i].da, tbl[i].db);
            check($sformatf("vec%0d_ready", i), lastReady, tbl[i].expReady);
            check($sformatf("vec%0d_busy", i), lastBusy, tbl[i].expBusy);
            check($sformatf("vec%0d_we", i), ctrl_writeEnable, tbl[i].expWe);
            check($sformatf("vec%0d_wreg", i), ctrl_writeReg, tbl[i].expReg);
            check($sformatf("vec%0d_wdata", i), data_writeReg, tbl[i].expData);
            check($sformatf("vec%0d_gid", i), grant_id, tbl[i].expGid);
        end
        check("rd_r5", rdReg(5), 32'hDEADBEEF);
        check("rd_r3", rdReg(3), 32'hA0A0A0A0);
        check("rd_r4", rdReg(4), 32'hB1B1B1B1);

        // Clear sequence with requester 0 waiting throughout.
        for (int k = 1; k < 32; k++) doCycle(0, 0, 2'b01, 5'(k), 5'd0, 32'hFFFFFFFF, 32'h0);
        doCycle(0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        check("preload_r17", rdReg(17), 32'hFFFFFFFF);
        doCycle(0, 1, 2'b01, 5'd7, 5'd0, 32'h55555555, 32'h0);
        check("clr_start_ready", lastReady, 2'b00);
        busyCnt = 0;
        for (int k = 1; k < 32; k++) begin
            doCycle(0, 0, 2'b01, 5'd7, 5'd0, 32'h55555555, 32'h0);
            if (lastBusy) busyCnt++;
            check($sformatf("clr_step%0d", k), {ctrl_writeEnable, ctrl_writeReg, data_writeReg},
                  {1'b1, 5'(k), 32'h0});
        end
        check("clr_busy_cycles", busyCnt, 31);
        doCycle(0, 0, 2'b01, 5'd7, 5'd0, 32'h55555555, 32'h0);
        check("post_clr_accept", lastReady, 2'b01);
        bad = 0;
        for (int r = 1; r < 32; r++) if (rdReg(r) !== 32'd0) bad++;
        check("clr_all_zero", bad, 0);
        doCycle(0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        check("rd_r7", rdReg(7), 32'h55555555);

        // Reset while the clear counter sits at 10.
        for (int k = 1; k < 32; k++) doCycle(0, 0, 2'b01, 5'(k), 5'd0, 32'hFFFFFFFF, 32'h0);
        doCycle(0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        doCycle(0, 1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        for (int k = 1; k < 10; k++) doCycle(0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        doCycle(1, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        check("rst_mid_busy", clear_busy, 1'b0);
        check("rst_mid_we", ctrl_writeEnable, 1'b0);
        bad = 0;
        for (int r = 1; r < 10; r++) if (rdReg(r) !== 32'd0) bad++;
        check("rst_mid_low_zero", bad, 0);
        bad = 0;
        for (int r = 10; r < 32; r++) if (rdReg(r) !== 32'hFFFFFFFF) bad++;
        check("rst_mid_high_kept", bad, 0);

        // Randomized traffic against the reference model.
        cv = 2'b00;
        for (int n = 0; n < 2000; n++) begin
            bit rRst;
            bit rClr;
            rRst = ($urandom_range(0, 199) == 0);
            rClr = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!cv[i]) begin
                    cv[i] = ($urandom_range(0, 9) < 6);
                    cr[i] = 5'($urandom_range(0, 31));
                    cd[i] = $urandom;
                end else if ($urandom_range(0, 9) == 0) begin
                    cv[i] = 1'b0;
                end
            end
            doCycle(rRst, rClr, cv, cr[0], cr[1], cd[0], cd[1]);
            cv = cv & ~lastReady;
        end
        repeat (35) doCycle(0, 0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        bad = 0;
        for (int r = 1; r < 32; r++) if (rdReg(r) !== shadow[r]) bad++;
        check("rand_rf_contents", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
